// File: rtl/ysyx_22050078_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state and owner
// encodings, default widths, and a grant-to-owner helper.
package ysyx_22050078_mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Grant vectors are indexed by owner encoding: bit 0 = IFU, bit 1 = LSU.
  function automatic owner_e owner_of_grant(input logic [1:0] grant);
    owner_e own;
    if (grant[1]) begin
      own = OWN_LSU;
    end else begin
      own = OWN_IFU;
    end
    return own;
  endfunction

endpackage

// File: rtl/ysyx_22050078_rr_pick2.sv
// Two-way round-robin picker: a lone valid wins; on a tie the requester
// that was not granted last wins.
module ysyx_22050078_rr_pick2
  import ysyx_22050078_mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_i,
  output logic [1:0] grant_o,
  output owner_e     next_last_o
);

  // Grant selection and updated last-grant owner
  always_comb begin
    grant_o     = 2'b00;
    next_last_o = last_i;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
        if (last_i == OWN_LSU) begin
          grant_o = 2'b01;
        end else begin
          grant_o = 2'b10;
        end
      end
      default: grant_o = 2'b00;
    endcase
    if (grant_o != 2'b00) begin
      next_last_o = owner_of_grant(grant_o);
    end else begin
      next_last_o = last_i;
    end
  end

endmodule

// File: rtl/ysyx_22050078_mem_arb.sv
// Shares one downstream memory port between IFU and LSU, one transaction at a
// time (IDLE -> SEND -> WAIT), with a watchdog that force-completes stalls.
module ysyx_22050078_mem_arb
  import ysyx_22050078_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_resp_data,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wstrb,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_resp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    o_timeout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic [1:0]              grant_s;
  owner_e                  next_last_s;
  logic                    expire_s;
  logic                    resp_fire_s;
  logic [DATA_WIDTH-1:0]   resp_data_s;

  ysyx_22050078_rr_pick2 u_pick (
    .valid_i     ({lsu_req_valid, ifu_req_valid}),
    .last_i      (last_q),
    .grant_o     (grant_s),
    .next_last_o (next_last_s)
  );

  // The counter holds the number of WAIT cycles already completed, so it
  // expires during the TIMEOUT_CYC-th WAIT cycle.
  assign expire_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, request latching and handshake outputs
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    resp_fire_s   = 1'b0;
    resp_data_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          state_d = ST_SEND;
          owner_d = owner_of_grant(grant_s);
          last_d  = next_last_s;
          if (grant_s[1]) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_req_addr;
            wen_d         = lsu_req_wen;
            wdata_d       = lsu_req_wdata;
            wstrb_d       = lsu_req_wstrb;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_req_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wstrb_d       = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real response in the expiry cycle takes priority over the watchdog.
        if (mem_resp_valid) begin
          resp_fire_s = 1'b1;
          resp_data_s = mem_resp_data;
          state_d     = ST_IDLE;
        end else if (expire_s) begin
          resp_fire_s = 1'b1;
          resp_data_s = '0;
          timeout_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IFU;
      last_q    <= OWN_LSU;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_req_valid  = (state_q == ST_SEND);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign o_timeout      = timeout_q;

  assign ifu_resp_valid = resp_fire_s & (owner_q == OWN_IFU);
  assign lsu_resp_valid = resp_fire_s & (owner_q == OWN_LSU);
  assign ifu_resp_data  = ifu_resp_valid ? resp_data_s : '0;
  assign lsu_resp_data  = lsu_resp_valid ? resp_data_s : '0;

endmodule

// File: tb/tb_ysyx_22050078_mem_arb.sv
// Transaction-level bench for the memory arbiter: directed scenarios plus
// randomized traffic, predicted from grant/latency arithmetic.
module tb_ysyx_22050078_mem_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [7:0]  lsu_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]  mem_req_wstrb;
  logic        o_timeout;

  ysyx_22050078_mem_arb #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pending requests, last winner (0 = IFU, 1 = LSU), sticky timeout.
  bit          ifu_pend, lsu_pend;
  logic [63:0] ifu_a, lsu_a, lsu_d;
  bit          lsu_w;
  logic [7:0]  lsu_s;
  int          last_win;
  bit          to_exp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    ifu_req_valid = ifu_pend;
    ifu_req_addr  = ifu_a;
    lsu_req_valid = lsu_pend;
    lsu_req_addr  = lsu_a;
    lsu_req_wen   = lsu_w;
    lsu_req_wdata = lsu_d;
    lsu_req_wstrb = lsu_s;
  endtask

  task automatic post_ifu(input logic [63:0] a);
    ifu_pend = 1'b1; ifu_a = a;
    drive_reqs();
  endtask

  task automatic post_lsu(input logic [63:0] a, input bit w, input logic [63:0] d, input logic [7:0] s);
    lsu_pend = 1'b1; lsu_a = a; lsu_w = w; lsu_d = d; lsu_s = s;
    drive_reqs();
  endtask

  task automatic check_quiet(input string tag, input bit full);
    check_val({tag, ".ifu_rdy"}, 64'(ifu_req_ready), 64'd0);
    check_val({tag, ".lsu_rdy"}, 64'(lsu_req_ready), 64'd0);
    check_val({tag, ".mem_vld"}, 64'(mem_req_valid), 64'd0);
    check_val({tag, ".ifu_rsp"}, 64'(ifu_resp_valid), 64'd0);
    check_val({tag, ".lsu_rsp"}, 64'(lsu_resp_valid), 64'd0);
    check_val({tag, ".tmo"}, 64'(o_timeout), 64'(to_exp));
    if (full) begin
      check_val({tag, ".mem_addr"}, mem_req_addr, 64'd0);
      check_val({tag, ".mem_wen"}, 64'(mem_req_wen), 64'd0);
      check_val({tag, ".mem_wdata"}, mem_req_wdata, 64'd0);
      check_val({tag, ".mem_wstrb"}, 64'(mem_req_wstrb), 64'd0);
      check_val({tag, ".ifu_data"}, ifu_resp_data, 64'd0);
      check_val({tag, ".lsu_data"}, lsu_resp_data, 64'd0);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_quiet("idle", 1'b0);
    @(posedge clk); #1;
  endtask

  // One transaction from accept to response. Called at posedge+1 with the DUT
  // idle and at least one request pending. rspdly >= TMO means no response.
  task automatic run_txn(input int rdly, input int rspdly, input bit early, input logic [63:0] rdata);
    int          win, a_rel, e_rel;
    bit          noresp;
    logic [63:0] e_addr, e_wdata, e_data;
    logic [7:0]  e_wstrb;
    bit          e_wen;
    if (ifu_pend && lsu_pend) win = (last_win == 1) ? 0 : 1;
    else win = lsu_pend ? 1 : 0;
    last_win = win;
    if (win == 1) begin
      e_addr = lsu_a; e_wen = lsu_w; e_wdata = lsu_d; e_wstrb = lsu_s;
    end else begin
      e_addr = ifu_a; e_wen = 1'b0; e_wdata = 64'd0; e_wstrb = 8'd0;
    end
    noresp = (rspdly >= TMO);
    a_rel  = 1 + rdly;
    e_rel  = noresp ? (a_rel + TMO) : (a_rel + 1 + rspdly);
    e_data = noresp ? 64'd0 : rdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    check_val("grant.ifu_rdy", 64'(ifu_req_ready), 64'(win == 0));
    check_val("grant.lsu_rdy", 64'(lsu_req_ready), 64'(win == 1));
    check_val("grant.mem_vld", 64'(mem_req_valid), 64'd0);
    if (win == 1) lsu_pend = 1'b0; else ifu_pend = 1'b0;
    for (int t = 1; t <= e_rel; t++) begin
      @(posedge clk); #1;
      drive_reqs();
      if (t == a_rel) mem_req_ready = 1'b1;
      else if (t > a_rel) mem_req_ready = 1'($urandom_range(0, 1));
      else mem_req_ready = 1'b0;
      mem_resp_valid = (!noresp && t == e_rel) || (early && t <= a_rel && $urandom_range(0, 1) == 1);
      mem_resp_data  = (t == e_rel) ? rdata : {$urandom(), $urandom()};
      @(negedge clk);
      check_val("txn.mem_vld", 64'(mem_req_valid), 64'(t <= a_rel));
      if (t <= a_rel) begin
        check_val("txn.mem_addr", mem_req_addr, e_addr);
        check_val("txn.mem_wen", 64'(mem_req_wen), 64'(e_wen));
        check_val("txn.mem_wstrb", 64'(mem_req_wstrb), 64'(e_wstrb));
        if (win == 1) check_val("txn.mem_wdata", mem_req_wdata, e_wdata);
      end
      check_val("txn.ifu_rdy", 64'(ifu_req_ready), 64'd0);
      check_val("txn.lsu_rdy", 64'(lsu_req_ready), 64'd0);
      check_val("txn.ifu_rsp", 64'(ifu_resp_valid), 64'(t == e_rel && win == 0));
      check_val("txn.lsu_rsp", 64'(lsu_resp_valid), 64'(t == e_rel && win == 1));
      if (t == e_rel && win == 0) check_val("txn.ifu_data", ifu_resp_data, e_data);
      if (t == e_rel && win == 1 && !e_wen) check_val("txn.lsu_data", lsu_resp_data, e_data);
      check_val("txn.tmo", 64'(o_timeout), 64'(to_exp));
    end
    if (noresp) to_exp = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_pend = 1'b0; lsu_pend = 1'b0;
    drive_reqs();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
    @(posedge clk); #1;
    last_win = 1; to_exp = 1'b0;
    @(negedge clk);
    check_quiet("rst", 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic reset_in_wait();
    post_ifu(64'h8000_2000);
    @(negedge clk);
    check_val("rw.ifu_rdy", 64'(ifu_req_ready), 64'd1);
    ifu_pend = 1'b0; last_win = 0;
    @(posedge clk); #1;
    drive_reqs(); mem_req_ready = 1'b1;
    @(negedge clk);
    check_val("rw.mem_vld", 64'(mem_req_valid), 64'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_val("rw.wait_rsp", 64'(ifu_resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1234_5678_9ABC_DEF0;
    last_win = 1; to_exp = 1'b0;
    @(negedge clk);
    check_quiet("rw.late", 1'b1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_quiet("rw.after", 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    ifu_a = 64'd0; lsu_a = 64'd0; lsu_d = 64'd0; lsu_w = 1'b0; lsu_s = 8'd0;
    do_reset();

    // IFU alone, zero-wait memory
    post_ifu(64'h8000_0000);
    run_txn(0, 0, 1'b0, 64'h0000_0013_0000_0413);
    idle_cycle();

    // Tie from reset goes to IFU, held LSU follows, next tie alternates
    do_reset();
    post_ifu(64'h8000_0004);
    post_lsu(64'h8000_0100, 1'b0, 64'd0, 8'h00);
    run_txn(0, 0, 1'b0, 64'h1111_2222_3333_4444);
    run_txn(0, 1, 1'b0, 64'h5555_6666_7777_8888);
    post_ifu(64'h8000_0008);
    post_lsu(64'h8000_0108, 1'b0, 64'd0, 8'h00);
    run_txn(0, 0, 1'b0, 64'hAAAA_0000_BBBB_0000);
    run_txn(1, 0, 1'b0, 64'hCCCC_DDDD_EEEE_FFFF);

    // Store stalled four cycles on mem_req_ready, early response in SEND
    post_lsu(64'h8000_1000, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    run_txn(4, 0, 1'b0, 64'd0);
    post_ifu(64'h8000_0010);
    run_txn(2, 2, 1'b1, 64'h0BAD_F00D_0000_0001);

    // Watchdog: response in the expiry cycle wins, then a real timeout
    post_lsu(64'h8000_0200, 1'b0, 64'd0, 8'h00);
    run_txn(0, TMO - 1, 1'b0, 64'h7777_7777_0000_0007);
    post_ifu(64'h8000_0014);
    run_txn(1, TMO, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    post_lsu(64'h8000_0208, 1'b0, 64'd0, 8'h00);
    run_txn(0, 0, 1'b0, 64'h0102_0304_0506_0708);

    reset_in_wait();
    post_lsu(64'h8000_0300, 1'b1, 64'h99, 8'hFF);
    run_txn(0, 0, 1'b0, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (!ifu_pend && $urandom_range(0, 1) == 1) post_ifu({$urandom(), $urandom()});
      if (!lsu_pend && $urandom_range(0, 1) == 1)
        post_lsu({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 8'($urandom()));
      if (!ifu_pend && !lsu_pend) begin
        idle_cycle();
      end else begin
        int rs;
        case ($urandom_range(0, 7))
          0:       rs = TMO + 1;
          1:       rs = TMO - 1;
          default: rs = $urandom_range(0, 3);
        endcase
        run_txn($urandom_range(0, 3), rs, 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
